// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    // Stores only have signed-width encodings; loads add the unsigned ones.
    function automatic logic is_legal(input logic we, input logic [2:0] func3);
        if (we) return func3 inside {F3_B, F3_H, F3_W};
        return func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // Natural alignment check: halves on even bytes, words on 4-byte bounds.
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] a);
        case (func3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the core and the data memory.
interface dmem_responder_if #(parameter int W = 32);
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [2:0]   req_func3;
    logic [W-1:0] req_addr;
    logic [W-1:0] req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_rdata;
    logic         rsp_err;

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment: lane i is byte (addr+i) of the access, so no shifting
// is needed; this block only extends load data and picks store byte enables.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]      func3_i,
    input  logic [3:0][7:0] rbytes_i,
    output logic [31:0]     rdata_o,
    input  logic [31:0]     wdata_i,
    output logic [3:0]      be_o,
    output logic [3:0][7:0] wbytes_o
);

    // Load extension by access size and signedness.
    always_comb begin
        rdata_o = '0;
        case (func3_i)
            F3_B:    rdata_o = {{24{rbytes_i[0][7]}}, rbytes_i[0]};
            F3_H:    rdata_o = {{16{rbytes_i[1][7]}}, rbytes_i[1], rbytes_i[0]};
            F3_W:    rdata_o = rbytes_i;
            F3_BU:   rdata_o = {24'h0, rbytes_i[0]};
            F3_HU:   rdata_o = {16'h0, rbytes_i[1], rbytes_i[0]};
            default: rdata_o = '0;
        endcase
    end

    // Store byte enables; data lanes map straight from wdata.
    always_comb begin
        wbytes_o = wdata_i;
        be_o     = 4'b0000;
        case (func3_i)
            F3_B:    be_o = 4'b0001;
            F3_H:    be_o = 4'b0011;
            F3_W:    be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states (LAT).
// Optional: define DMEM_MISALIGN_ERR_EN to flag misaligned half/word accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int W   = 32,
    parameter int AW  = 12,
    parameter int LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    dmem_responder_if.slave   bus,
    output logic              busy_o
);

    localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_access;

    logic            we_q;
    logic [2:0]      f3_q;
    logic [W-1:0]    addr_q, wdata_q;

    logic            rsp_valid_q;
    logic [W-1:0]    rdata_q;
    logic            err_q;

    logic [7:0]      mem [2**AW];

    // In IDLE the access (LAT=0) uses the live request; later, the captured one.
    logic            idle;
    logic            acc_we, acc_err;
    logic [2:0]      acc_f3;
    logic [W-1:0]    acc_addr, acc_wdata;
    logic            unused_addr;

    assign idle      = (state_q == IDLE);
    assign acc_we    = idle ? bus.req_we    : we_q;
    assign acc_f3    = idle ? bus.req_func3 : f3_q;
    assign acc_addr  = idle ? bus.req_addr  : addr_q;
    assign acc_wdata = idle ? bus.req_wdata : wdata_q;
    assign unused_addr = ^acc_addr[W-1:AW];

`ifdef DMEM_MISALIGN_ERR_EN
    assign acc_err = !is_legal(acc_we, acc_f3) || is_misaligned(acc_f3, acc_addr[1:0]);
`else
    assign acc_err = !is_legal(acc_we, acc_f3);
`endif

    // Byte addresses wrap modulo the array size.
    logic [3:0][AW-1:0] idx;
    logic [3:0][7:0]    rbytes, wbytes;
    logic [3:0]         be;
    logic [31:0]        ld_data;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign idx[i]    = acc_addr[AW-1:0] + AW'(i);
        assign rbytes[i] = mem[idx[i]];
    end

    dmem_lane_align u_align (
        .func3_i  (acc_f3),
        .rbytes_i (rbytes),
        .rdata_o  (ld_data),
        .wdata_i  (acc_wdata),
        .be_o     (be),
        .wbytes_o (wbytes)
    );

    // Next-state logic: accept, count wait states, hold response until taken.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                cnt_d = CW'(LAT);
                if (LAT == 0) begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and captured request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (idle && bus.req_valid) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_func3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    // Response registers, loaded at the access edge and cleared on hand-off.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else if (do_access) begin
            rsp_valid_q <= 1'b1;
            rdata_q     <= (acc_we || acc_err) ? '0 : W'(ld_data);
            err_q       <= acc_err;
        end else if (state_q == RESP && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Array write; contents survive reset, but nothing commits while held in it.
    always_ff @(posedge clk_i) begin
        if (rst_ni && do_access && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx[i]] <= wbytes[i];
        end
    end

    assign bus.req_ready = idle;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy_o        = !idle;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one LAT=2 and one LAT=0 instance, each checked
// against a byte-array reference model, plus directed corner cases.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        vld_a = 1'b0, vld_b = 1'b0, rdy_a = 1'b0, rdy_b = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        busy_a, busy_b;

    int n_chk = 0;
    int n_fail = 0;

    dmem_responder_if #(.W(32)) bus_a ();
    dmem_responder_if #(.W(32)) bus_b ();

    assign bus_a.req_valid = vld_a;
    assign bus_a.rsp_ready = rdy_a;
    assign bus_a.req_we    = we;
    assign bus_a.req_func3 = f3;
    assign bus_a.req_addr  = addr;
    assign bus_a.req_wdata = wdata;
    assign bus_b.req_valid = vld_b;
    assign bus_b.rsp_ready = rdy_b;
    assign bus_b.req_we    = we;
    assign bus_b.req_func3 = f3;
    assign bus_b.req_addr  = addr;
    assign bus_b.req_wdata = wdata;

    dmem_responder #(.W(32), .AW(12), .LAT(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_a), .busy_o(busy_a));
    dmem_responder #(.W(32), .AW(12), .LAT(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_b), .busy_o(busy_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // {req_ready, rsp_valid, rsp_err, busy, rsp_rdata}
    function automatic logic [35:0] obs(input int s);
        if (s == 0) return {bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_err, busy_a, bus_a.rsp_rdata};
        return {bus_b.req_ready, bus_b.rsp_valid, bus_b.rsp_err, busy_b, bus_b.rsp_rdata};
    endfunction

    task automatic set_vld(input int s, input logic v);
        if (s == 0) vld_a = v; else vld_b = v;
    endtask

    task automatic set_rdy(input int s, input logic v);
        if (s == 0) rdy_a = v; else rdy_b = v;
    endtask

    // Reference memory: one 4 KiB byte array per instance.
    logic [7:0] mem_m [2][4096];

    function automatic void ref_access(input int s, input logic w, input logic [2:0] f,
                                       input logic [31:0] a, input logic [31:0] d,
                                       output logic [31:0] rd, output logic er);
        int n;
        int base;
        logic [31:0] v;
        n    = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        base = int'(a & 32'hFFF);
        er   = w ? (f > 3'd2) : !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef DMEM_MISALIGN_ERR_EN
        if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) er = 1'b1;
`endif
        rd = 32'd0;
        if (er) return;
        if (w) begin
            for (int i = 0; i < n; i++) mem_m[s][(base + i) % 4096] = d[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(mem_m[s][(base + i) % 4096]) << (8 * i));
            if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
    endfunction

    // One transaction, entered and left at #1 after a rising edge with the DUT idle.
    task automatic txn(input int s, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d, input int hold,
                       output logic [31:0] rd, output logic er);
        logic [31:0] erd;
        logic        eer;
        logic [35:0] o, o0;
        int          n;
        o = obs(s);
        check("req_ready_idle", 32'(o[35]), 32'd1);
        we = w; f3 = f; addr = a; wdata = d;
        set_vld(s, 1'b1);
        @(posedge clk); #1;
        set_vld(s, 1'b0);
        ref_access(s, w, f, a, d, erd, eer);
        n = 0;
        o = obs(s);
        while (!o[34] && n < 20) begin
            @(posedge clk); #1;
            n++;
            o = obs(s);
        end
        check("rsp_latency", 32'(n), (s == 0) ? 32'd2 : 32'd0);
        o0 = obs(s);
        rd = o0[31:0];
        er = o0[33];
        check("rdata", rd, erd);
        check("err", 32'(er), 32'(eer));
        check("busy_resp", 32'(o0[32]), 32'd1);
        if (hold > 0) begin
            // a store offered while the response is pending must be ignored
            we = 1'b1; f3 = 3'd2; addr = 32'h40; wdata = 32'h55AA55AA;
            set_vld(s, 1'b1);
            repeat (hold) begin
                @(posedge clk); #1;
                o = obs(s);
                check("rsp_stable", o[34:3], o0[34:3]);
                check("req_ready_hold", 32'(o[35]), 32'd0);
            end
            set_vld(s, 1'b0);
        end
        set_rdy(s, 1'b1);
        @(posedge clk); #1;
        set_rdy(s, 1'b0);
        o = obs(s);
        check("rsp_valid_drop", 32'(o[34]), 32'd0);
        check("req_ready_after", 32'(o[35]), 32'd1);
    endtask

    initial begin
        logic [31:0] rd, erd;
        logic        er, eer;
        logic [35:0] o;
        int          cnt;
        logic [31:0] ra;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 4096; i++) mem_m[s][i] = 8'h00;

        #2;
        o = obs(0);
        check("rst_rsp_valid", 32'(o[34]), 32'd0);
        check("rst_rdata", o[31:0], 32'd0);
        check("rst_err", 32'(o[33]), 32'd0);
        check("rst_busy", 32'(o[32]), 32'd0);
        check("rst_req_ready", 32'(o[35]), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // fill the windows used by loads so nothing reads uninitialised bytes
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 32; i++) txn(s, 1'b1, 3'd2, 32'(i * 4), $urandom, 0, rd, er);
            for (int i = 0; i < 4; i++) txn(s, 1'b1, 3'd2, 32'hFF0 + 32'(i * 4), $urandom, 0, rd, er);
        end

        // directed LAT=2 sequence
        txn(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
        check("sw_rdata", rd, 32'd0);
        check("sw_err", 32'(er), 32'd0);
        txn(0, 1'b0, 3'd2, 32'h10, 32'd0, 5, rd, er);
        check("lw_10", rd, 32'hDEADBEEF);
        txn(0, 1'b0, 3'd0, 32'h13, 32'd0, 0, rd, er);
        check("lb_13", rd, 32'hFFFFFFDE);
        txn(0, 1'b0, 3'd4, 32'h13, 32'd0, 0, rd, er);
        check("lbu_13", rd, 32'h000000DE);
        txn(0, 1'b0, 3'd1, 32'h12, 32'd0, 0, rd, er);
        check("lh_12", rd, 32'hFFFFDEAD);
        txn(0, 1'b0, 3'd5, 32'h10, 32'd0, 0, rd, er);
        check("lhu_10", rd, 32'h0000BEEF);
        txn(0, 1'b1, 3'd0, 32'h11, 32'h12, 0, rd, er);
        txn(0, 1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
        check("lw_after_sb", rd, 32'hDEAD12EF);
        txn(0, 1'b0, 3'd2, 32'h40, 32'd0, 0, rd, er);  // ignored store left 0x40 alone

        // illegal encodings
        txn(0, 1'b1, 3'd3, 32'h20, 32'h12345678, 0, rd, er);
        check("ill_store_err", 32'(er), 32'd1);
        check("ill_store_rdata", rd, 32'd0);
        txn(0, 1'b0, 3'd2, 32'h20, 32'd0, 0, rd, er);
        txn(0, 1'b0, 3'd6, 32'h20, 32'd0, 0, rd, er);
        check("ill_load_err", 32'(er), 32'd1);
        check("ill_load_rdata", rd, 32'd0);

        // misaligned word
        txn(0, 1'b0, 3'd2, 32'h12, 32'd0, 0, rd, er);
`ifdef DMEM_MISALIGN_ERR_EN
        check("misalign_err", 32'(er), 32'd1);
`else
        check("misalign_ok", 32'(er), 32'd0);
`endif

        // LAT=0 aliasing of upper address bits
        txn(1, 1'b1, 3'd2, 32'h1010, 32'hCAFEF00D, 0, rd, er);
        txn(1, 1'b0, 3'd2, 32'h010, 32'd0, 0, rd, er);
        check("alias_010", rd, 32'hCAFEF00D);

        // LAT=0 back-to-back throughput: one response every two cycles
        ref_access(1, 1'b0, 3'd2, 32'h10, 32'd0, erd, eer);
        we = 1'b0; f3 = 3'd2; addr = 32'h10;
        rdy_b = 1'b1; vld_b = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            o = obs(1);
            if (o[34]) begin
                cnt++;
                check("b2b_rdata", o[31:0], erd);
            end
        end
        vld_b = 1'b0;
        @(posedge clk); #1;
        rdy_b = 1'b0;
        check("b2b_count", 32'(cnt), 32'd5);

        // reset during WAIT discards the store
        we = 1'b1; f3 = 3'd2; addr = 32'h30; wdata = 32'h1;
        vld_a = 1'b1;
        @(posedge clk); #1;
        vld_a = 1'b0;
        o = obs(0);
        check("wait_busy", 32'(o[32]), 32'd1);
        rst_n = 1'b0;
        #1;
        o = obs(0);
        check("mid_rst_valid", 32'(o[34]), 32'd0);
        check("mid_rst_busy", 32'(o[32]), 32'd0);
        check("mid_rst_ready", 32'(o[35]), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        txn(0, 1'b0, 3'd2, 32'h30, 32'd0, 0, rd, er);

        // randomized traffic on both instances
        for (int k = 0; k < 300; k++) begin
            int s;
            s  = int'($urandom_range(0, 1));
            ra = $urandom_range(0, 1) ? 32'($urandom_range(0, 'h70)) : 32'hFF0 + 32'($urandom_range(0, 15));
            ra = ra | ($urandom & 32'hFFFFF000);
            txn(s, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
                int'($urandom_range(0, 2)), rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
